// File: rtl/uart_pkg.sv
// Shared types and sizing helpers for the uart_rx_tx transceiver.
// Both FSMs and the bit timer size themselves from these functions.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // Clock cycles per serial bit; integer division truncates.
  function automatic int calc_cpb(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction

  function automatic int bit_cnt_width(input int payload_bits);
    return $clog2(payload_bits + 1);
  endfunction

  function automatic int cyc_cnt_width(input int cpb);
    return $clog2(cpb + 1);
  endfunction

endpackage

// File: rtl/uart_rx_tx_if.sv
// Serial pins and system-side byte handshakes of the uart_rx_tx transceiver.
// slave is the transceiver side, master the pin/system side driving it.
interface uart_rx_tx_if #(
  parameter int PAYLOAD_BITS = 8
);

  logic                    uart_rxd;
  logic                    uart_rx_en;
  logic                    uart_rx_break;
  logic                    uart_rx_valid;
  logic [PAYLOAD_BITS-1:0] uart_rx_data;
  logic                    uart_txd;
  logic                    uart_tx_en;
  logic                    uart_tx_busy;
  logic [PAYLOAD_BITS-1:0] uart_tx_data;

  modport slave (
    input  uart_rxd,
    input  uart_rx_en,
    output uart_rx_break,
    output uart_rx_valid,
    output uart_rx_data,
    output uart_txd,
    input  uart_tx_en,
    output uart_tx_busy,
    input  uart_tx_data
  );

  modport master (
    output uart_rxd,
    output uart_rx_en,
    input  uart_rx_break,
    input  uart_rx_valid,
    input  uart_rx_data,
    input  uart_txd,
    output uart_tx_en,
    input  uart_tx_busy,
    output uart_tx_data
  );

endinterface

// File: rtl/uart_bit_timer.sv
// Free-running CPB-period counter. expire is high during the last cycle of each
// bit period; clear restarts a full period, load_half restarts a half period.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CPB = 2604
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic load_half,
  output logic expire
);

  localparam int CW = cyc_cnt_width(CPB);
  localparam logic [CW-1:0] LAST       = CW'(CPB - 1);
  // Starting here leaves exactly CPB/2 cycles until expire.
  localparam logic [CW-1:0] HALF_START = CW'(CPB - CPB / 2);

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  assign expire = (cnt_reg == LAST);

  always_comb begin
    cnt_next = cnt_reg + 1'b1;
    if (load_half) begin
      cnt_next = HALF_START;
    end else if (clear || expire) begin
      cnt_next = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/uart_rx_tx.sv
// Full-duplex 8N1 UART: independent receiver and transmitter sharing clock,
// reset and bit-rate configuration. Each direction owns one uart_bit_timer.
module uart_rx_tx
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = 25_000_000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8
) (
  input  logic        clk,
  input  logic        resetn,
  uart_rx_tx_if.slave bus
);

  localparam int CPB = calc_cpb(CLK_HZ, BIT_RATE);
  localparam int BW  = bit_cnt_width(PAYLOAD_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(PAYLOAD_BITS - 1);

  // ---------------- receiver ----------------
  logic                    rxd_meta_reg;
  logic                    rxd_sync_reg;
  uart_state_t             rx_state_reg, rx_state_next;
  logic [BW-1:0]           rx_bit_reg, rx_bit_next;
  logic [PAYLOAD_BITS-1:0] rx_shift_reg, rx_shift_next;
  logic [PAYLOAD_BITS-1:0] rx_data_reg, rx_data_next;
  logic                    rx_valid_reg, rx_valid_next;
  logic                    rx_break_reg, rx_break_next;
  logic                    rx_wait_high_reg, rx_wait_high_next;
  logic                    rx_clear;
  logic                    rx_load_half;
  logic                    rx_expire;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rxd_meta_reg <= 1'b1;
      rxd_sync_reg <= 1'b1;
    end else begin
      rxd_meta_reg <= bus.uart_rxd;
      rxd_sync_reg <= rxd_meta_reg;
    end
  end

  uart_bit_timer #(
    .CPB (CPB)
  ) u_rx_timer (
    .clk       (clk),
    .resetn    (resetn),
    .clear     (rx_clear),
    .load_half (rx_load_half),
    .expire    (rx_expire)
  );

  always_comb begin
    rx_state_next     = rx_state_reg;
    rx_bit_next       = rx_bit_reg;
    rx_shift_next     = rx_shift_reg;
    rx_data_next      = rx_data_reg;
    rx_valid_next     = 1'b0;
    rx_break_next     = 1'b0;
    rx_wait_high_next = rx_wait_high_reg;
    rx_clear          = 1'b0;
    rx_load_half      = 1'b0;

    if (!bus.uart_rx_en) begin
      rx_state_next     = IDLE;
      rx_wait_high_next = 1'b0;
      rx_clear          = 1'b1;
    end else begin
      case (rx_state_reg)
        IDLE: begin
          if (!rxd_sync_reg) begin
            rx_state_next = START;
            rx_load_half  = 1'b1;
          end else begin
            rx_clear = 1'b1;
          end
        end
        START: begin
          // Mid start bit: a line already back high was only a glitch.
          if (rx_expire) begin
            if (rxd_sync_reg) begin
              rx_state_next = IDLE;
            end else begin
              rx_state_next = DATA;
              rx_bit_next   = '0;
            end
          end
        end
        DATA: begin
          if (rx_expire) begin
            rx_shift_next = {rxd_sync_reg, rx_shift_reg[PAYLOAD_BITS-1:1]};
            rx_bit_next   = rx_bit_reg + 1'b1;
            if (rx_bit_reg == LAST_BIT) begin
              rx_state_next = STOP;
            end
          end
        end
        STOP: begin
          if (rx_wait_high_reg) begin
            if (rxd_sync_reg) begin
              rx_state_next     = IDLE;
              rx_wait_high_next = 1'b0;
            end
          end else if (rx_expire) begin
            if (rxd_sync_reg) begin
              rx_data_next  = rx_shift_reg;
              rx_valid_next = 1'b1;
              rx_state_next = IDLE;
            end else begin
              // Low stop bit: all-zero payload is a BREAK, anything else is dropped.
              rx_break_next     = (rx_shift_reg == '0);
              rx_wait_high_next = 1'b1;
            end
          end
        end
        default: rx_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_state_reg     <= IDLE;
      rx_bit_reg       <= '0;
      rx_shift_reg     <= '0;
      rx_data_reg      <= '0;
      rx_valid_reg     <= 1'b0;
      rx_break_reg     <= 1'b0;
      rx_wait_high_reg <= 1'b0;
    end else begin
      rx_state_reg     <= rx_state_next;
      rx_bit_reg       <= rx_bit_next;
      rx_shift_reg     <= rx_shift_next;
      rx_data_reg      <= rx_data_next;
      rx_valid_reg     <= rx_valid_next;
      rx_break_reg     <= rx_break_next;
      rx_wait_high_reg <= rx_wait_high_next;
    end
  end

  assign bus.uart_rx_valid = rx_valid_reg;
  assign bus.uart_rx_break = rx_break_reg;
  assign bus.uart_rx_data  = rx_data_reg;

  // ---------------- transmitter ----------------
  uart_state_t             tx_state_reg, tx_state_next;
  logic [BW-1:0]           tx_bit_reg, tx_bit_next;
  logic [PAYLOAD_BITS-1:0] tx_shift_reg, tx_shift_next;
  logic                    txd_reg, txd_next;
  logic                    tx_clear;
  logic                    tx_expire;

  uart_bit_timer #(
    .CPB (CPB)
  ) u_tx_timer (
    .clk       (clk),
    .resetn    (resetn),
    .clear     (tx_clear),
    .load_half (1'b0),
    .expire    (tx_expire)
  );

  always_comb begin
    tx_state_next = tx_state_reg;
    tx_bit_next   = tx_bit_reg;
    tx_shift_next = tx_shift_reg;
    txd_next      = txd_reg;
    tx_clear      = 1'b0;

    case (tx_state_reg)
      IDLE: begin
        // Holding the timer clear here aligns the start bit to the accept edge.
        tx_clear = 1'b1;
        txd_next = 1'b1;
        if (bus.uart_tx_en) begin
          tx_state_next = START;
          tx_shift_next = bus.uart_tx_data;
          txd_next      = 1'b0;
        end
      end
      START: begin
        if (tx_expire) begin
          tx_state_next = DATA;
          txd_next      = tx_shift_reg[0];
          tx_shift_next = tx_shift_reg >> 1;
          tx_bit_next   = '0;
        end
      end
      DATA: begin
        if (tx_expire) begin
          if (tx_bit_reg == LAST_BIT) begin
            tx_state_next = STOP;
            txd_next      = 1'b1;
          end else begin
            txd_next      = tx_shift_reg[0];
            tx_shift_next = tx_shift_reg >> 1;
            tx_bit_next   = tx_bit_reg + 1'b1;
          end
        end
      end
      STOP: begin
        if (tx_expire) begin
          tx_state_next = IDLE;
        end
      end
      default: tx_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_state_reg <= IDLE;
      tx_bit_reg   <= '0;
      tx_shift_reg <= '0;
      txd_reg      <= 1'b1;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_bit_reg   <= tx_bit_next;
      tx_shift_reg <= tx_shift_next;
      txd_reg      <= txd_next;
    end
  end

  assign bus.uart_txd     = txd_reg;
  assign bus.uart_tx_busy = (tx_state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_tx.sv
// Directed bench for uart_rx_tx at a reduced bit period (CPB = 40); received
// and transmitted bytes are checked against scoreboard queues.
module tb_uart_rx_tx;

  localparam int CLK_HZ   = 2_000_000;
  localparam int BIT_RATE = 50_000;
  localparam int PB       = 8;
  localparam int CPB      = CLK_HZ / BIT_RATE;
  localparam int FRAME    = (PB + 2) * CPB;

  logic          clk         = 1'b0;
  logic          resetn      = 1'b0;
  logic          rxd_drv     = 1'b1;
  logic          rx_en_drv   = 1'b1;
  logic          tx_en_drv   = 1'b0;
  logic          loop_en     = 1'b0;
  logic [PB-1:0] tx_data_drv = '0;

  int vectors      = 0;
  int miscompares  = 0;
  int rx_valid_cnt = 0;
  int rx_break_cnt = 0;
  int tx_frame_cnt = 0;

  logic [PB-1:0] rx_exp_q[$];
  logic [PB-1:0] tx_exp_q[$];

  always #10 clk = ~clk;

  uart_rx_tx_if #(.PAYLOAD_BITS(PB)) bus ();

  assign bus.uart_rxd     = rxd_drv;
  assign bus.uart_rx_en   = rx_en_drv;
  assign bus.uart_tx_en   = loop_en ? bus.uart_rx_valid : tx_en_drv;
  assign bus.uart_tx_data = loop_en ? bus.uart_rx_data : tx_data_drv;

  uart_rx_tx #(
    .CLK_HZ       (CLK_HZ),
    .BIT_RATE     (BIT_RATE),
    .PAYLOAD_BITS (PB)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_rx_frame(input logic [PB-1:0] b, input int bit_cyc);
    rxd_drv = 1'b0;
    cycles(bit_cyc);
    for (int i = 0; i < PB; i++) begin
      rxd_drv = b[i];
      cycles(bit_cyc);
    end
    rxd_drv = 1'b1;
    cycles(bit_cyc);
  endtask

  task automatic wait_tx_frames(input int target, input string tag);
    int n;
    n = 0;
    while (tx_frame_cnt < target && n < 4 * FRAME) begin
      cycles(1);
      n++;
    end
    check(tag, tx_frame_cnt, target);
  endtask

  task automatic wait_tx_idle(input string tag);
    int n;
    n = 0;
    while (bus.uart_tx_busy === 1'b1 && n < 2 * FRAME) begin
      cycles(1);
      n++;
    end
    check(tag, 32'(bus.uart_tx_busy), 0);
  endtask

  // Receiver-side scoreboard: every valid pulse pops one expected byte.
  initial begin : rx_mon
    forever begin
      @(negedge clk);
      if (resetn === 1'b1) begin
        if (bus.uart_rx_valid === 1'b1) begin
          rx_valid_cnt++;
          if (rx_exp_q.size() != 0)
            check("rx_data", 32'(bus.uart_rx_data), 32'(rx_exp_q.pop_front()));
        end
        if (bus.uart_rx_break === 1'b1) rx_break_cnt++;
      end
    end
  end

  // Transmitter-side scoreboard: decode txd at mid-bit and pop one expected byte per frame.
  initial begin : tx_mon
    bit            active;
    int            t;
    logic [PB-1:0] sh;
    active = 1'b0;
    t      = 0;
    sh     = '0;
    forever begin
      @(negedge clk);
      if (resetn !== 1'b1) begin
        active = 1'b0;
      end else if (!active) begin
        if (bus.uart_txd === 1'b0) begin
          active = 1'b1;
          t      = 0;
        end
      end else begin
        t++;
        if (t % CPB == CPB / 2) begin
          if (t / CPB <= PB) begin
            sh = {bus.uart_txd, sh[PB-1:1]};
          end else begin
            active = 1'b0;
            tx_frame_cnt++;
            check("tx_stop_bit", 32'(bus.uart_txd), 1);
            if (tx_exp_q.size() != 0)
              check("tx_byte", 32'(sh), 32'(tx_exp_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #800_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [PB+1:0] fr;
    int            busy_hi;

    // Reset state
    cycles(3);
    check("rst_txd", 32'(bus.uart_txd), 1);
    check("rst_busy", 32'(bus.uart_tx_busy), 0);
    check("rst_rx_valid", 32'(bus.uart_rx_valid), 0);
    check("rst_rx_break", 32'(bus.uart_rx_break), 0);
    check("rst_rx_data", 32'(bus.uart_rx_data), 0);
    resetn = 1'b1;
    cycles(3);

    // TX 0xA5: exact bit boundaries and busy length
    fr = {1'b1, 8'hA5, 1'b0};
    busy_hi = 0;
    tx_data_drv = 8'hA5;
    tx_en_drv   = 1'b1;
    tx_exp_q.push_back(8'hA5);
    cycles(1);
    tx_en_drv = 1'b0;
    for (int t = 1; t <= FRAME + 1; t++) begin
      if (bus.uart_tx_busy === 1'b1) busy_hi++;
      if (t <= FRAME && ((t - 1) % CPB == 0 || t % CPB == 0))
        check($sformatf("tx_a5_bit%0d_t%0d", (t - 1) / CPB, t),
              32'(bus.uart_txd), 32'(fr[(t - 1) / CPB]));
      if (t == FRAME + 1) check("tx_busy_after_frame", 32'(bus.uart_tx_busy), 0);
      else cycles(1);
    end
    check("tx_busy_cycles", busy_hi, FRAME);
    wait_tx_frames(1, "tx_a5_frames");

    // tx_en while busy is ignored; data changes mid-frame have no effect
    tx_data_drv = 8'h3C;
    tx_en_drv   = 1'b1;
    tx_exp_q.push_back(8'h3C);
    cycles(1);
    tx_en_drv = 1'b0;
    cycles(3 * CPB);
    tx_data_drv = 8'hC3;
    tx_en_drv   = 1'b1;
    cycles(1);
    tx_en_drv   = 1'b0;
    tx_data_drv = 8'hFF;
    wait_tx_idle("tx_3c_idle");
    // enable on the first idle cycle is accepted
    tx_data_drv = 8'h96;
    tx_en_drv   = 1'b1;
    tx_exp_q.push_back(8'h96);
    cycles(1);
    tx_en_drv = 1'b0;
    check("tx_b2b_accept", {30'd0, bus.uart_tx_busy, bus.uart_txd}, 32'b10);
    wait_tx_frames(3, "tx_b2b_frames");
    wait_tx_idle("tx_96_idle");
    cycles(2 * CPB);
    check("tx_no_extra_frame", tx_frame_cnt, 3);

    // RX 0x31 at nominal rate
    rx_exp_q.push_back(8'h31);
    drive_rx_frame(8'h31, CPB);
    cycles(CPB);
    check("rx_31_valid_cnt", rx_valid_cnt, 1);
    check("rx_31_break_cnt", rx_break_cnt, 0);
    check("rx_31_hold", 32'(bus.uart_rx_data), 32'h31);

    // RX with sender slightly fast and slightly slow
    rx_exp_q.push_back(8'hC6);
    drive_rx_frame(8'hC6, CPB + 1);
    rx_exp_q.push_back(8'h5A);
    drive_rx_frame(8'h5A, CPB - 1);
    cycles(CPB);
    check("rx_tol_valid_cnt", rx_valid_cnt, 3);

    // BREAK: line low for 10 bit times
    rxd_drv = 1'b0;
    cycles(10 * CPB);
    rxd_drv = 1'b1;
    cycles(2 * CPB);
    check("rx_break_cnt", rx_break_cnt, 1);
    check("rx_break_no_valid", rx_valid_cnt, 3);
    check("rx_break_data_hold", 32'(bus.uart_rx_data), 32'h5A);
    rx_exp_q.push_back(8'h55);
    drive_rx_frame(8'h55, CPB);
    cycles(CPB);
    check("rx_55_valid_cnt", rx_valid_cnt, 4);
    check("rx_55_break_cnt", rx_break_cnt, 1);

    // Short low glitch is rejected
    rxd_drv = 1'b0;
    cycles(15);
    rxd_drv = 1'b1;
    cycles(12 * CPB);
    check("rx_glitch_valid_cnt", rx_valid_cnt, 4);

    // Disabling the receiver mid-frame aborts it
    rxd_drv = 1'b0;
    cycles(2 * CPB);
    rx_en_drv = 1'b0;
    cycles(2);
    rxd_drv = 1'b1;
    cycles(3);
    rx_en_drv = 1'b1;
    cycles(12 * CPB);
    check("rx_abort_valid_cnt", rx_valid_cnt, 4);

    // Loopback echo of 0x37
    loop_en = 1'b1;
    rx_exp_q.push_back(8'h37);
    tx_exp_q.push_back(8'h37);
    fork
      drive_rx_frame(8'h37, CPB);
      begin : lb_watch
        int n;
        n = 0;
        while (bus.uart_rx_valid !== 1'b1 && n < 2 * FRAME) begin
          cycles(1);
          n++;
        end
        check("lb_valid_seen", 32'(bus.uart_rx_valid), 1);
        check("lb_txd_idle_at_valid", 32'(bus.uart_txd), 1);
        cycles(1);
        check("lb_tx_start", {30'd0, bus.uart_tx_busy, bus.uart_txd}, 32'b10);
      end
    join
    wait_tx_frames(4, "lb_tx_frames");
    wait_tx_idle("lb_tx_idle");
    loop_en = 1'b0;

    // Asynchronous reset mid-frame in both directions
    tx_data_drv = 8'h81;
    tx_en_drv   = 1'b1;
    cycles(1);
    tx_en_drv = 1'b0;
    rxd_drv   = 1'b0;
    cycles(3 * CPB);
    resetn = 1'b0;
    #1;
    check("rst_mid_txd", 32'(bus.uart_txd), 1);
    check("rst_mid_busy", 32'(bus.uart_tx_busy), 0);
    check("rst_mid_rx_valid", 32'(bus.uart_rx_valid), 0);
    check("rst_mid_rx_data", 32'(bus.uart_rx_data), 0);
    rxd_drv = 1'b1;
    cycles(3);
    resetn = 1'b1;
    cycles(2 * CPB);
    check("rst_mid_no_frame", tx_frame_cnt, 4);

    // Recovery after reset
    tx_data_drv = 8'hE7;
    tx_en_drv   = 1'b1;
    tx_exp_q.push_back(8'hE7);
    cycles(1);
    tx_en_drv = 1'b0;
    rx_exp_q.push_back(8'h0F);
    drive_rx_frame(8'h0F, CPB);
    wait_tx_frames(5, "post_rst_tx_frames");
    cycles(CPB);
    check("post_rst_rx_valid_cnt", rx_valid_cnt, 6);
    check("rx_queue_drained", rx_exp_q.size(), 0);
    check("tx_queue_drained", tx_exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
